// File: rtl/ber_result_logger.sv
// ber_result_logger: counts bit errors in decoded hard-decision frames
// against the all-zero codeword. Errors are summed over a programmable
// window of frames, and each finished window becomes one result word
// {err_cnt_acc, snr} written to the result FIFO.
//
// Handshake: a frame is taken on any cycle with frame_valid_i=1 and
// frame_ready_o=1. A pulse while frame_ready_o=0 is discarded and sets the
// sticky frame_drop_o. A FIFO write happens on a cycle with
// result_fifo_we=1, and result_fifo_we is never high while
// result_fifo_full=1.
module ber_result_logger #(
   parameter int N                   = 204,
   parameter int CHUNK               = 34,
   parameter int ERR_CNT_PACKET_SIZE = 28,
   parameter int SNR_PACKET_SIZE     = 4,
   parameter int FRAME_CNT_WIDTH     = 20,
   parameter int WARMUP_FRAMES       = 4
) (
   input  logic                                         sys_clk,
   input  logic                                         rstn,
   input  logic [N-1:0]                                 hard_decision_i,
   input  logic                                         frame_valid_i,
   output logic                                         frame_ready_o,
   input  logic [SNR_PACKET_SIZE-1:0]                   snr_packet_i,
   input  logic [FRAME_CNT_WIDTH-1:0]                   frames_per_report_i,
   output logic [ERR_CNT_PACKET_SIZE+SNR_PACKET_SIZE-1:0] result_fifo_in,
   output logic                                         result_fifo_we,
   input  logic                                         result_fifo_full,
   output logic [FRAME_CNT_WIDTH-1:0]                   block_cnt_o,
   output logic [ERR_CNT_PACKET_SIZE-1:0]               err_cnt_acc_o,
   output logic                                         frame_drop_o,
   output logic [1:0]                                   state_o
);

   localparam int NCHUNK = N / CHUNK;
   localparam int FEW    = $clog2(N + 1);
   localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int EW     = ERR_CNT_PACKET_SIZE;
   localparam int FCW    = FRAME_CNT_WIDTH;
   localparam int RW     = ERR_CNT_PACKET_SIZE + SNR_PACKET_SIZE;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_ACCUM  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t                     state_q;
   logic [N-1:0]               shreg_q;
   logic [CIW-1:0]             chunk_idx_q;
   logic [FEW-1:0]             frame_err_q;
   logic [FCW-1:0]             block_cnt_q;
   logic [FCW-1:0]             win_cnt_q;
   logic [EW-1:0]              acc_q;
   logic [SNR_PACKET_SIZE-1:0] win_snr_q;
   logic [RW-1:0]              last_word_q;
   logic                       drop_q;

   logic [FEW-1:0]             frame_err_d;
   logic [EW:0]                acc_sum;
   logic [EW-1:0]              acc_d;
   logic [FCW:0]               win_inc;
   logic [FCW-1:0]             fpr_eff;
   logic [FCW-1:0]             block_cnt_d;
   logic                       warmup;
   logic                       report_now;
   logic                       wr_fire;

   function automatic logic [FEW-1:0] popcount(input logic [CHUNK-1:0] v);
      logic [FEW-1:0] c;
      c = '0;
      for (int i = 0; i < CHUNK; i++) c = c + FEW'(v[i]);
      return c;
   endfunction

   // Next-value arithmetic: chunk popcount, saturating sums, window compare
   always_comb begin
      frame_err_d = frame_err_q + popcount(shreg_q[CHUNK-1:0]);
      acc_sum     = {1'b0, acc_q} + (EW+1)'(frame_err_q);
      acc_d       = acc_sum[EW] ? '1 : acc_sum[EW-1:0];
      win_inc     = {1'b0, win_cnt_q} + (FCW+1)'(1);
      fpr_eff     = (frames_per_report_i == '0) ? FCW'(1) : frames_per_report_i;
      report_now  = (win_inc >= {1'b0, fpr_eff});
      block_cnt_d = (&block_cnt_q) ? block_cnt_q : block_cnt_q + FCW'(1);
      warmup      = (block_cnt_q < FCW'(WARMUP_FRAMES));
      wr_fire     = (state_q == S_REPORT) && !result_fifo_full;
   end

   // Control FSM together with every counter it owns
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         chunk_idx_q <= '0;
         frame_err_q <= '0;
         block_cnt_q <= '0;
         win_cnt_q   <= '0;
         acc_q       <= '0;
         win_snr_q   <= '0;
         last_word_q <= '0;
         drop_q      <= 1'b0;
      end else begin
         // A pulse outside IDLE (including the REPORT write cycle) is lost
         if (frame_valid_i && (state_q != S_IDLE)) drop_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (frame_valid_i) begin
                  shreg_q     <= hard_decision_i;
                  chunk_idx_q <= '0;
                  frame_err_q <= '0;
                  state_q     <= S_COUNT;
               end
            end
            S_COUNT: begin
               frame_err_q <= frame_err_d;
               shreg_q     <= shreg_q >> CHUNK;
               chunk_idx_q <= chunk_idx_q + CIW'(1);
               if (chunk_idx_q == CIW'(NCHUNK - 1)) state_q <= S_ACCUM;
            end
            S_ACCUM: begin
               block_cnt_q <= block_cnt_d;
               if (warmup) begin
                  // Pipeline-fill frames are counted but their errors are dropped
                  state_q <= S_IDLE;
               end else begin
                  acc_q     <= acc_d;
                  win_cnt_q <= win_inc[FCW-1:0];
                  if (win_cnt_q == '0) win_snr_q <= snr_packet_i;
                  state_q <= report_now ? S_REPORT : S_IDLE;
               end
            end
            S_REPORT: begin
               if (wr_fire) begin
                  last_word_q <= {acc_q, win_snr_q};
                  acc_q       <= '0;
                  win_cnt_q   <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // The write strobe follows FIFO full within the REPORT cycle; between
   // writes the data bus keeps showing the last word written.
   assign result_fifo_we = wr_fire;
   assign result_fifo_in = wr_fire ? {acc_q, win_snr_q} : last_word_q;
   assign frame_ready_o  = (state_q == S_IDLE);
   assign block_cnt_o    = block_cnt_q;
   assign err_cnt_acc_o  = acc_q;
   assign frame_drop_o   = drop_q;
   assign state_o        = state_q;

endmodule
